commit_packer: RTL

COMMIT_PACKER -- requirements
Module: commit_packer

---
 rtl/NVP_v1_constants.sv | 12 +
 rtl/commit_word_shifter.sv | 17 +
 rtl/commit_packer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/NVP_v1_constants.sv
// Shared constants and types for the NVP v1 datapath blocks.
package NVP_v1_constants;

    localparam int ACTIVATION_BANK_BIT_WIDTH = 128;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_FLUSH = 2'd2
    } commit_packer_state_t;

endpackage

// File: rtl/commit_word_shifter.sv
// Word-granular left shifter: shifts a vector left by a run-time number of words, zero-filling.
module commit_word_shifter #(
    parameter int WORD_W    = 8,
    parameter int NUM_WORDS = 24,
    parameter int SHIFT_W   = 5
) (
    input  logic [NUM_WORDS*WORD_W-1:0] vec_i,
    input  logic [SHIFT_W-1:0]          shift_i,
    output logic [NUM_WORDS*WORD_W-1:0] vec_o
);

    logic [31:0] shamt;

    assign shamt = 32'(shift_i) * 32'(WORD_W);
    assign vec_o = vec_i << shamt;

endmodule

// File: rtl/commit_packer.sv
// Packs variable-length input beats into fixed-width output words, first word at the MSB.
module commit_packer
    import NVP_v1_constants::*;
#(
    parameter int DATA_BIT_WIDTH            = 8,
    parameter int IN_WORDS                  = 9,
    parameter int ACTIVATION_BANK_BIT_WIDTH = NVP_v1_constants::ACTIVATION_BANK_BIT_WIDTH
) (
    input  logic                                                   clk,
    input  logic                                                   resetn,
    input  logic                                                   i_valid,
    output logic                                                   o_ready,
    input  logic [$clog2(IN_WORDS+1)-1:0]                          i_count,
    input  logic [IN_WORDS*DATA_BIT_WIDTH-1:0]                     i_data,
    input  logic                                                   i_last,
    output logic                                                   o_valid,
    input  logic                                                   i_ready,
    output logic [ACTIVATION_BANK_BIT_WIDTH-1:0]                   o_data,
    output logic [$clog2(ACTIVATION_BANK_BIT_WIDTH/DATA_BIT_WIDTH+1)-1:0] o_fill,
    output logic                                                   o_last
);

    localparam int OUT_WORDS = ACTIVATION_BANK_BIT_WIDTH / DATA_BIT_WIDTH;
    localparam int BUF_WORDS = OUT_WORDS + IN_WORDS - 1;
    localparam int BUF_BITS  = BUF_WORDS * DATA_BIT_WIDTH;
    localparam int OUT_BITS  = OUT_WORDS * DATA_BIT_WIDTH;
    localparam int IN_BITS   = IN_WORDS * DATA_BIT_WIDTH;
    localparam int FILL_W    = $clog2(BUF_WORDS + 1);
    localparam int CNT_W     = $clog2(IN_WORDS + 1);
    localparam int OFILL_W   = $clog2(OUT_WORDS + 1);

    commit_packer_state_t state_q, state_d;
    logic [BUF_BITS-1:0]  buf_q, buf_d;
    logic [FILL_W-1:0]    fill_q, fill_d;

    logic [CNT_W-1:0]     cnt;
    logic [IN_BITS-1:0]   in_masked;
    logic [BUF_BITS-1:0]  in_vec;
    logic [BUF_BITS-1:0]  in_placed;
    logic [FILL_W-1:0]    shift_words;

    always_comb begin
        cnt = (i_count > CNT_W'(IN_WORDS)) ? CNT_W'(IN_WORDS) : i_count;
        in_masked = '0;
        for (int w = 0; w < IN_WORDS; w++) begin
            if (w < int'(cnt)) begin
                in_masked[(IN_WORDS-1-w)*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] =
                    i_data[(IN_WORDS-1-w)*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
            end
        end
    end

    // Beat sits in the low words; shifting left by (OUT_WORDS-1-fill) lands its first word at fill.
    // Only meaningful in FILL, where fill never exceeds OUT_WORDS-1.
    assign in_vec      = {{(BUF_BITS-IN_BITS){1'b0}}, in_masked};
    assign shift_words = FILL_W'(OUT_WORDS - 1) - fill_q;

    commit_word_shifter #(
        .WORD_W    (DATA_BIT_WIDTH),
        .NUM_WORDS (BUF_WORDS),
        .SHIFT_W   (FILL_W)
    ) u_shifter (
        .vec_i   (in_vec),
        .shift_i (shift_words),
        .vec_o   (in_placed)
    );

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        fill_d  = fill_q;
        case (state_q)
            ST_FILL: begin
                if (i_valid) begin
                    buf_d  = buf_q | in_placed;
                    fill_d = fill_q + FILL_W'(cnt);
                    if (i_last)
                        state_d = ST_FLUSH;
                    else if (fill_d >= FILL_W'(OUT_WORDS))
                        state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (i_ready) begin
                    buf_d   = buf_q << OUT_BITS;
                    fill_d  = fill_q - FILL_W'(OUT_WORDS);
                    state_d = ST_FILL;
                end
            end
            ST_FLUSH: begin
                if (i_ready) begin
                    if (fill_q > FILL_W'(OUT_WORDS)) begin
                        buf_d  = buf_q << OUT_BITS;
                        fill_d = fill_q - FILL_W'(OUT_WORDS);
                    end else begin
                        buf_d   = '0;
                        fill_d  = '0;
                        state_d = ST_FILL;
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_FILL;
            buf_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        o_data = '0;
        for (int w = 0; w < OUT_WORDS; w++) begin
            if (w < int'(fill_q)) begin
                o_data[(OUT_WORDS-1-w)*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] =
                    buf_q[(BUF_WORDS-1-w)*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
            end
        end
    end

    assign o_ready = (state_q == ST_FILL);
    assign o_valid = (state_q != ST_FILL);
    assign o_last  = (state_q == ST_FLUSH) && (fill_q <= FILL_W'(OUT_WORDS));
    assign o_fill  = (fill_q > FILL_W'(OUT_WORDS)) ? OFILL_W'(OUT_WORDS) : OFILL_W'(fill_q);

endmodule
